// File: rtl/video_pkg.sv
// Shared types and slot constants for the video RAM slot sequencer.
package video_pkg;

  typedef enum logic [1:0] {
    SLOT_PF  = 2'b00,
    SLOT_MO  = 2'b01,
    SLOT_AL  = 2'b10,
    SLOT_CPU = 2'b11
  } slot_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    ACK,
    RELEASE
  } cpu_state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } cpu_dir_e;

  localparam logic [2:0] CPU_RD_SLOT = 3'd3;
  localparam logic [2:0] CPU_WR_SLOT = 3'd7;

  // Reads may borrow any read-half slot while vblank boost is active.
  function automatic logic cpu_slot_hit(cpu_dir_e dir, logic [2:0] slot, logic boost);
    if (dir == DIR_WR) return slot == CPU_WR_SLOT;
    return (slot == CPU_RD_SLOT) || (boost && !slot[2]);
  endfunction

endpackage

// File: rtl/vram_slot_sequencer_if.sv
// CPU handshake and VRAM slot bus between the sequencer and its clients.
interface vram_slot_sequencer_if;
  logic       cpu_rd_req;
  logic       cpu_wr_req;
  logic       cpu_dtack_b;
  logic       cpu_err;
  logic [2:0] vrac;
  logic       vramrd_b;
  logic       vramwr;
  logic       pf_latch_b;
  logic       mo_latch_b;
  logic       al_latch_b;

  modport master (
    output cpu_rd_req, cpu_wr_req,
    input  cpu_dtack_b, cpu_err, vrac, vramrd_b, vramwr,
    input  pf_latch_b, mo_latch_b, al_latch_b
  );

  modport slave (
    input  cpu_rd_req, cpu_wr_req,
    output cpu_dtack_b, cpu_err, vrac, vramrd_b, vramwr,
    output pf_latch_b, mo_latch_b, al_latch_b
  );
endinterface

// File: rtl/vram_slot_counter.sv
// 3-bit wrapping VRAC slot counter with registered fetch-latch strobes.
module vram_slot_counter
  import video_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       en,
  output logic [2:0] vrac_o,
  output logic [2:0] vrac_next_o,
  output logic       pf_latch_b_o,
  output logic       mo_latch_b_o,
  output logic       al_latch_b_o
);

  logic [2:0] vrac_q, vrac_d;
  logic       pf_q, pf_d;
  logic       mo_q, mo_d;
  logic       al_q, al_d;
  slot_e      slot;

  always_comb begin
    slot   = slot_e'(vrac_q[1:0]);
    vrac_d = vrac_q + 3'd1;
    // each strobe is low during the tick that follows its fetch slot
    pf_d   = (slot != SLOT_PF);
    mo_d   = (slot != SLOT_MO);
    al_d   = (slot != SLOT_AL);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      vrac_q <= '0;
      pf_q   <= 1'b1;
      mo_q   <= 1'b1;
      al_q   <= 1'b1;
    end else if (en) begin
      vrac_q <= vrac_d;
      pf_q   <= pf_d;
      mo_q   <= mo_d;
      al_q   <= al_d;
    end
  end

  assign vrac_o       = vrac_q;
  assign vrac_next_o  = vrac_d;
  assign pf_latch_b_o = pf_q;
  assign mo_latch_b_o = mo_q;
  assign al_latch_b_o = al_q;

endmodule

// File: rtl/vram_slot_sequencer.sv
// VRAM time-slot sequencer: slot counter plus 68k access FSM on the CPU slots.
module vram_slot_sequencer
  import video_pkg::*;
#(
  parameter int unsigned VBLANK_BOOST = 1,
  parameter int unsigned DTACK_HOLD   = 1
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  en,
  input  logic                  vblank_b,
  vram_slot_sequencer_if.slave  bus
);

  localparam int unsigned HOLD_W = (DTACK_HOLD > 0) ? $clog2(DTACK_HOLD + 1) : 1;

  logic [2:0]        vrac, vrac_next;
  logic              pf_b, mo_b, al_b;
  logic              rd_req, wr_req, dir_req, boost;
  cpu_state_e        state_q, state_d;
  cpu_dir_e          dir_q, dir_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              err_q, err_d;
  logic              vramrd_b_q, vramrd_b_d;
  logic              vramwr_q, vramwr_d;
  logic              dtack_b_q, dtack_b_d;

  vram_slot_counter u_counter (
    .clk          (clk),
    .rst_b        (rst_b),
    .en           (en),
    .vrac_o       (vrac),
    .vrac_next_o  (vrac_next),
    .pf_latch_b_o (pf_b),
    .mo_latch_b_o (mo_b),
    .al_latch_b_o (al_b)
  );

  assign rd_req = bus.cpu_rd_req;
  assign wr_req = bus.cpu_wr_req;
  assign boost  = (VBLANK_BOOST != 0) && !vblank_b;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    err_d   = err_q | (rd_req & wr_req);
    dir_req = (dir_q == DIR_WR) ? wr_req : rd_req;
    unique case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          dir_d   = rd_req ? DIR_RD : DIR_WR;
          // a request already aligned with its slot skips WAIT so worst-case latency stays at 8 ticks
          state_d = cpu_slot_hit(dir_d, vrac_next, boost) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (!dir_req) state_d = IDLE;
        else if (cpu_slot_hit(dir_q, vrac_next, boost)) state_d = ACCESS;
      end
      ACCESS: begin
        state_d = ACK;
        hold_d  = HOLD_W'(DTACK_HOLD);
      end
      ACK: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        else if (!rd_req && !wr_req) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    vramrd_b_d = !((state_d == ACCESS) && (dir_d == DIR_RD));
    vramwr_d   = (state_d == ACCESS) && (dir_d == DIR_WR);
    dtack_b_d  = (state_d != ACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      dir_q      <= DIR_RD;
      hold_q     <= '0;
      err_q      <= 1'b0;
      vramrd_b_q <= 1'b1;
      vramwr_q   <= 1'b0;
      dtack_b_q  <= 1'b1;
    end else if (en) begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      vramrd_b_q <= vramrd_b_d;
      vramwr_q   <= vramwr_d;
      dtack_b_q  <= dtack_b_d;
    end
  end

  assign bus.vrac        = vrac;
  assign bus.pf_latch_b  = pf_b;
  assign bus.mo_latch_b  = mo_b;
  assign bus.al_latch_b  = al_b;
  assign bus.vramrd_b    = vramrd_b_q;
  assign bus.vramwr      = vramwr_q;
  assign bus.cpu_dtack_b = dtack_b_q;
  assign bus.cpu_err     = err_q;

endmodule

// File: tb/tb_vram_slot_sequencer.sv
// Bench for vram_slot_sequencer: vector table, directed CPU sequences, random run vs reference model.
module tb_vram_slot_sequencer;
  localparam int unsigned BOOST = 1;
  localparam int unsigned HOLD  = 1;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic en = 1'b0;
  logic vblank_b = 1'b1;
  logic rd = 1'b0;
  logic wr = 1'b0;

  vram_slot_sequencer_if bus ();
  assign bus.cpu_rd_req = rd;
  assign bus.cpu_wr_req = wr;

  vram_slot_sequencer #(.VBLANK_BOOST(BOOST), .DTACK_HOLD(HOLD)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .en       (en),
    .vblank_b (vblank_b),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "init";

  // Reference model: slot position, pending request, access flag, dtack age, release flag.
  int m_slot = 0;
  bit m_pend = 0;
  bit m_wr = 0;
  bit m_access = 0;
  bit m_release = 0;
  bit m_err = 0;
  int m_ack_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {bus.vrac, bus.vramrd_b, bus.vramwr, bus.pf_latch_b, bus.mo_latch_b,
            bus.al_latch_b, bus.cpu_dtack_b, bus.cpu_err};
  endfunction

  function automatic logic [9:0] mk_exp(int v, bit rd_b, bit wrp, bit dtack_b, bit err);
    logic [2:0] s;
    s = 3'(v);
    return {s, rd_b, wrp, s[1:0] != 2'd1, s[1:0] != 2'd2, s[1:0] != 2'd3, dtack_b, err};
  endfunction

  function automatic bit eligible(bit is_wr, int slot, bit vb_b);
    if (is_wr) return slot == 7;
    return (slot == 3) || (BOOST != 0 && !vb_b && slot < 4);
  endfunction

  task automatic model_step();
    bit was_access;
    if (!rst_b) begin
      m_slot = 0; m_pend = 0; m_wr = 0; m_access = 0;
      m_release = 0; m_err = 0; m_ack_n = 0;
      return;
    end
    if (!en) return;
    m_slot = (m_slot + 1) % 8;
    if (rd && wr) m_err = 1;
    was_access = m_access;
    m_access = 0;
    if (m_release) m_release = 0;
    else if (m_ack_n > 0) begin
      if (m_ack_n >= int'(HOLD) + 1 && !rd && !wr) begin
        m_ack_n = 0;
        m_release = 1;
      end else m_ack_n++;
    end else if (was_access) m_ack_n = 1;
    else if (m_pend && !(m_wr ? wr : rd)) m_pend = 0;
    else begin
      if (!m_pend && (rd || wr)) begin
        m_pend = 1;
        m_wr = !rd;
      end
      if (m_pend && eligible(m_wr, m_slot, vblank_b)) begin
        m_pend = 0;
        m_access = 1;
      end
    end
  endtask

  function automatic logic [9:0] model_exp();
    return mk_exp(m_slot, !(m_access && !m_wr), m_access && m_wr, m_ack_n == 0, m_err);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check($sformatf("model/%s", phase), 32'(outs()), 32'(model_exp()));
  endtask

  task automatic do_reset();
    rd = 0; wr = 0; en = 1; rst_b = 0;
    tick();
    rst_b = 1;
  endtask

  typedef struct {
    logic       rst_b;
    logic       en;
    logic       vblank_b;
    logic       rd;
    logic       wr;
    logic [9:0] exp;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int   lat, pulses, pulse_at, rd_acc, wr_acc, r;
    bit   found;

    // Table: reset, 19 free-running ticks, en=0 freeze, reset with en=0.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk_exp(0, 1, 0, 1, 0)});
    for (int i = 1; i <= 19; i++)
      vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk_exp(i % 8, 1, 0, 1, 0)});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk_exp(3, 1, 0, 1, 0)});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk_exp(3, 1, 0, 1, 0)});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk_exp(0, 1, 0, 1, 0)});

    phase = "table";
    for (int i = 0; i < vecs.size(); i++) begin
      rst_b = vecs[i].rst_b; en = vecs[i].en; vblank_b = vecs[i].vblank_b;
      rd = vecs[i].rd; wr = vecs[i].wr;
      tick();
      check($sformatf("table[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Read requested at vrac=4 is served at vrac=3, seven ticks later.
    phase = "rd_seq";
    do_reset();
    repeat (4) tick();
    rd = 1;
    lat = 0; found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      tick();
      if (bus.vramrd_b === 1'b0) begin found = 1; lat = k; end
    end
    check("rd_latency", 32'(lat), 32'd7);
    check("rd_slot", 32'(bus.vrac), 32'd3);
    tick();
    check("rd_dtack_on", 32'(bus.cpu_dtack_b), 32'd0);
    tick();
    check("rd_dtack_hold", 32'(bus.cpu_dtack_b), 32'd0);
    rd = 0;
    tick();
    check("rd_dtack_off", 32'(bus.cpu_dtack_b), 32'd1);
    tick();
    check("rd_idle", 32'({bus.vramrd_b, bus.cpu_dtack_b}), 32'b11);

    // Write requested at vrac=0: one pulse at vrac=7, then held request gives no second pulse.
    phase = "wr_seq";
    do_reset();
    wr = 1;
    pulses = 0; pulse_at = -1;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (bus.vramwr === 1'b1) begin
        pulses++;
        if (pulse_at < 0) pulse_at = k;
      end
      if (k == 8) check("wr_dtack_frame0", 32'({bus.vrac, bus.cpu_dtack_b}), 32'({3'd0, 1'b0}));
    end
    check("wr_pulses", 32'(pulses), 32'd1);
    check("wr_pulse_tick", 32'(pulse_at), 32'd7);
    check("wr_dtack_held", 32'(bus.cpu_dtack_b), 32'd0);
    wr = 0;
    tick();
    check("wr_dtack_off", 32'(bus.cpu_dtack_b), 32'd1);

    // Vblank boost: read at vrac=0 takes the first read-half slot.
    phase = "boost";
    do_reset();
    vblank_b = 0;
    rd = 1;
    lat = 0; found = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      tick();
      if (bus.vramrd_b === 1'b0) begin found = 1; lat = k; end
    end
    check("boost_latency", 32'(lat), 32'd1);
    check("boost_slot", 32'(bus.vrac), 32'd1);
    rd = 0;
    repeat (4) tick();
    vblank_b = 1;
    do_reset();
    rd = 1;
    lat = 0; found = 0;
    for (int k = 1; k <= 12 && !found; k++) begin
      tick();
      if (bus.vramrd_b === 1'b0) begin found = 1; lat = k; end
    end
    check("noboost_slot", 32'(bus.vrac), 32'd3);
    check("noboost_latency", 32'(lat), 32'd3);
    rd = 0;
    repeat (4) tick();

    // Simultaneous rd+wr: a single read, sticky error until reset.
    phase = "rdwr";
    do_reset();
    rd = 1; wr = 1;
    rd_acc = 0; wr_acc = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (bus.vramrd_b === 1'b0) rd_acc++;
      if (bus.vramwr === 1'b1) wr_acc++;
    end
    check("rdwr_reads", 32'(rd_acc), 32'd1);
    check("rdwr_writes", 32'(wr_acc), 32'd0);
    check("rdwr_err", 32'(bus.cpu_err), 32'd1);
    rd = 0; wr = 0;
    repeat (3) tick();
    check("rdwr_err_sticky", 32'(bus.cpu_err), 32'd1);
    rst_b = 0;
    tick();
    check("rdwr_err_cleared", 32'(bus.cpu_err), 32'd0);
    rst_b = 1;

    // Reset while a write waits at vrac=6 aborts it.
    phase = "rst_abort";
    do_reset();
    wr = 1;
    repeat (6) tick();
    check("abort_pre_slot", 32'(bus.vrac), 32'd6);
    rst_b = 0; wr = 0;
    tick();
    check("abort_reset_vals", 32'(outs()), 32'(mk_exp(0, 1, 0, 1, 0)));
    rst_b = 1;
    tick();
    check("abort_no_write", 32'({bus.vrac, bus.vramwr}), 32'({3'd1, 1'b0}));

    // Randomized traffic against the reference model.
    phase = "random";
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      r = int'($urandom_range(0, 99));
      rst_b = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 4) vblank_b = ~vblank_b;
      if (!rd && !wr) begin
        if (r < 10) rd = 1;
        else if (r < 18) wr = 1;
        else if (r < 20) begin rd = 1; wr = 1; end
      end else if (bus.cpu_dtack_b === 1'b0) begin
        if (r < 35) begin rd = 0; wr = 0; end
      end else if (r < 3) begin
        rd = 0; wr = 0;
      end
      tick();
      if (bus.vramwr === 1'b1) check("inv_wr_slot", 32'(bus.vrac), 32'd7);
      if (bus.vramrd_b === 1'b0) check("inv_rd_half", 32'(bus.vrac[2]), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
